pixel_wise_filter_pipe: RTL and testbench
=========================================

# pixel_wise_filter_pipe

Streaming, multi-channel pixel-wise filter: each channel of each pixel is transformed independently from its own value and a BPM-derived brightness level. Successor to the single-channel combinational pixel filter. Adds a registered valid/ready pipeline stage, four filter modes, frame-aligned configuration latching and optional brightness ramping. Sits between the pixel source and the display/output stage in the video path.

## Interface
- CHANNELS, 3, colour channels packed per beat (channel 0 in LSBs)
- BITS, 8, bits per channel
- MAX_BPM, 200, BPM clamp ceiling
- STEP_SIZE, 327, brightness scale (Q8); BPM=MAX_BPM gives ≈ full scale
- RAMP_STEP, 16, max brightness change per frame (used only with ramp compiled in)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  CHANNELS*BITS  input pixel
- in_valid  in  1  input beat valid
- in_sop  in  1  first pixel of frame, qualified by in_valid
- in_ready  out  1  block accepts beat this cycle
- filter_enable  in  1  0 = pass-through
- filter_mode  in  2  0 threshold, 1 average, 2 saturating add, 3 binarise
- bpm_estimate  in  $clog2(MAX_BPM+1)  BPM input
- out_data  out  CHANNELS*BITS  filtered pixel
- out_valid  out  1  output beat valid
- out_sop  out  1  delayed in_sop
- out_ready  in  1  downstream accepts beat
- brightness  out  BITS  active brightness level

## Operation
- Beat accepted when in_valid && in_ready.
- Target brightness: bpm_c = min(bpm_estimate, MAX_BPM); t = (STEP_SIZE*bpm_c)>>8, saturated to 2^BITS-1. Product computed at full width before shift; no truncation before saturation.
- Active config (enable, mode, brightness b) updates only on an accepted beat with in_sop=1; the new config applies to that beat onward. Input changes mid-frame have no effect until the next accepted sop.
- Per channel p (BITS wide), when active enable=1:
  - mode 0: p <= b -> 0, else p
  - mode 1: (p + b) >> 1, sum BITS+1 wide
  - mode 2: min(p + b, 2^BITS-1)
  - mode 3: p > b -> 2^BITS-1, else 0
- Active enable=0: out_data = in_data unchanged; beats still flow.
- Output register loads filtered data and in_sop on accept; out_valid set on accept, cleared when out_ready && no new accept.

## Timing
- Latency: 1 cycle, accept to out_valid.
- in_ready = !out_valid || out_ready (combinational from out_ready). Full throughput (1 beat/cycle) when out_ready held high.
- While out_valid && !out_ready: out_data, out_sop held stable; in_ready=0.
- Simultaneous out_ready and accept: register replaced in same cycle, out_valid stays 1, no bubble.
- brightness output reflects active b, changes the cycle after the accepted sop.
- Reset (any time, including mid-frame or stalled): out_valid=0, out_sop=0, out_data=0, brightness=0, active enable=0, active mode=0. Pending output beat is discarded. Until the first sop after reset, beats pass through unmodified.

## Configuration
- BRIGHT_RAMP_EN defined: on each accepted sop, b moves toward t by at most RAMP_STEP; if |t-b| <= RAMP_STEP, b = t. No overflow or underflow past t.
- BRIGHT_RAMP_EN undefined: on each accepted sop, b = t directly. RAMP_STEP unused.

## Test plan
- Threshold: bpm=100 (b=127), mode 0, sop then pixels 127 and 128 on all channels -> out 0 and 128; out_valid 1 cycle after each accept.
- Average/add/binarise: bpm=100, p=255 -> mode1 191, mode2 255 (saturated); p=100 -> mode2 227, mode3 0; p=200 -> mode3 255.
- Clamp/limits: bpm=250 -> brightness 255; bpm=0, mode 0 -> p=0 outputs 0, p=1 outputs 1.
- Backpressure: 8-beat burst, out_ready toggled 1,0,0,1,...: no beat lost or duplicated, data stable during stall, in_ready=0 while stalled.
- Config latching: mode changed 0->2 mid-frame -> old mode until next sop beat, new mode from that beat. Ramp (BRIGHT_RAMP_EN, RAMP_STEP=16): bpm 0->200 -> b = 16, 32, ..., 240, 255 on successive sops. Without the macro: 255 on first sop.
- Reset mid-stall: assert reset with out_valid=1, out_ready=0 -> next cycle out_valid=0, brightness=0; post-reset non-sop beat passes through unmodified.

Source files
------------

// File: rtl/pixel_wise_filter_pipe.sv
// Multi-channel pixel-wise filter with one registered valid/ready stage and frame-aligned config.
// Optional compile macro BRIGHT_RAMP_EN: limits the brightness change per frame to RAMP_STEP.
module pixel_wise_filter_pipe #(
  parameter int CHANNELS  = 3,
  parameter int BITS      = 8,
  parameter int MAX_BPM   = 200,
  parameter int STEP_SIZE = 327,
  parameter int RAMP_STEP = 16,
  parameter int BPM_W     = $clog2(MAX_BPM + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS*BITS-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_sop,
  output logic                     in_ready,
  input  logic                     filter_enable,
  input  logic [1:0]               filter_mode,
  input  logic [BPM_W-1:0]         bpm_estimate,
  output logic [CHANNELS*BITS-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  input  logic                     out_ready,
  output logic [BITS-1:0]          brightness
);

  localparam logic [BITS-1:0] PIX_MAX = '1;

  // Handshake: a beat moves when valid && ready on the same edge. The output register
  // may be refilled in the cycle it is drained, so in_ready only drops on a stalled output.
  logic accept;
  logic sop_accept;
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign sop_accept = accept && in_sop;

  logic            cfg_enable;
  logic [1:0]      cfg_mode;
  logic [BITS-1:0] cfg_b;

  logic [BPM_W-1:0] bpm_c;
  logic [31:0]      prod;
  logic [31:0]      scaled;
  logic [BITS-1:0]  target;
  logic [BITS-1:0]  b_next;

  always_comb begin
    bpm_c  = (bpm_estimate > BPM_W'(MAX_BPM)) ? BPM_W'(MAX_BPM) : bpm_estimate;
    prod   = 32'(STEP_SIZE) * 32'(bpm_c);
    scaled = prod >> 8;
    target = (scaled > 32'(PIX_MAX)) ? PIX_MAX : scaled[BITS-1:0];
  end

`ifdef BRIGHT_RAMP_EN
  // Step toward the target; the last step lands exactly on it so b never overshoots.
  always_comb begin
    b_next = target;
    if (32'(target) > 32'(cfg_b) + 32'(RAMP_STEP)) begin
      b_next = cfg_b + BITS'(RAMP_STEP);
    end else if (32'(target) + 32'(RAMP_STEP) < 32'(cfg_b)) begin
      b_next = cfg_b - BITS'(RAMP_STEP);
    end
  end
`else
  assign b_next = target;
`endif

  // A sop beat is filtered with the configuration it is latching, not the previous one.
  logic            eff_enable;
  logic [1:0]      eff_mode;
  logic [BITS-1:0] eff_b;
  assign eff_enable = sop_accept ? filter_enable : cfg_enable;
  assign eff_mode   = sop_accept ? filter_mode   : cfg_mode;
  assign eff_b      = sop_accept ? b_next        : cfg_b;

  logic [CHANNELS*BITS-1:0] filtered;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [BITS-1:0] p;
    logic [BITS:0]   sum;
    logic [BITS-1:0] f;

    assign p   = in_data[c*BITS +: BITS];
    assign sum = {1'b0, p} + {1'b0, eff_b};

    always_comb begin
      f = p;
      if (eff_enable) begin
        case (eff_mode)
          2'd0:    f = (p <= eff_b) ? '0 : p;
          2'd1:    f = sum[BITS:1];
          2'd2:    f = sum[BITS] ? PIX_MAX : sum[BITS-1:0];
          default: f = (p > eff_b) ? PIX_MAX : '0;
        endcase
      end
    end

    assign filtered[c*BITS +: BITS] = f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      cfg_enable <= 1'b0;
      cfg_mode   <= 2'd0;
      cfg_b      <= '0;
    end else begin
      if (accept) begin
        out_data  <= filtered;
        out_sop   <= in_sop;
        out_valid <= 1'b1;
        if (in_sop) begin
          cfg_enable <= filter_enable;
          cfg_mode   <= filter_mode;
          cfg_b      <= b_next;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign brightness = cfg_b;

endmodule

// File: tb/tb_pixel_wise_filter_pipe.sv
// Directed bench for pixel_wise_filter_pipe: vector table plus backpressure, ramp and reset sequences.
module tb_pixel_wise_filter_pipe;

  logic        clk;
  logic        reset;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_ready;
  logic        filter_enable;
  logic [1:0]  filter_mode;
  logic [7:0]  bpm_estimate;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_ready;
  logic [7:0]  brightness;

  int tests = 0;
  int fails = 0;

  pixel_wise_filter_pipe dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
    .filter_enable(filter_enable), .filter_mode(filter_mode), .bpm_estimate(bpm_estimate),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_ready(out_ready),
    .brightness(brightness)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sop;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  bpm;
    logic [23:0] pix;
    logic [23:0] exp_data;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sop", 32'(out_sop), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_brightness", 32'(brightness), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // driver: one beat with out_ready high, checked #1 after the accepting edge
  task automatic send(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_sop = v.sop;
    filter_enable = v.en;
    filter_mode = v.mode;
    bpm_estimate = v.bpm;
    in_data = v.pix;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(v.exp_data));
    chk({tag, "_sop"}, 32'(out_sop), 32'(v.sop));
    chk({tag, "_bright"}, 32'(brightness), 32'(v.exp_b));
  endtask

  // mode 2 with b=127, channel by channel
  function automatic logic [23:0] sat_add127(input logic [23:0] d);
    logic [23:0] r;
    int s;
    for (int c = 0; c < 3; c++) begin
      s = int'(d[c*8 +: 8]) + 127;
      r[c*8 +: 8] = (s > 255) ? 8'hff : 8'(s);
    end
    return r;
  endfunction

  function automatic logic [23:0] bp_data(input int i);
    return {8'(i * 50), 8'(i * 9 + 3), 8'(i * 31)};
  endfunction

  logic [23:0] exp_q[$];

  initial begin
    vec_t v;
    int sent;
    int got;
    int stalls;
    logic prev_stall;
    logic [23:0] prev_data;
    logic acc;
    logic take;

    reset = 1'b1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_data = '0;
    filter_enable = 1'b0;
    filter_mode = 2'd0;
    bpm_estimate = 8'd0;
    out_ready = 1'b1;

    vecs[0]  = '{1'b1, 1'b1, 2'd0, 8'd100, 24'h7f7f7f, 24'h000000, 8'd127};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'd100, 24'h808080, 24'h808080, 8'd127};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 8'd0,   24'h7f7f7f, 24'h000000, 8'd127};
    vecs[3]  = '{1'b0, 1'b1, 2'd2, 8'd0,   24'h101010, 24'h000000, 8'd127};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 8'd100, 24'h646464, 24'he3e3e3, 8'd127};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 8'd100, 24'hffffff, 24'hffffff, 8'd127};
    vecs[6]  = '{1'b1, 1'b1, 2'd1, 8'd100, 24'hffffff, 24'hbfbfbf, 8'd127};
    vecs[7]  = '{1'b1, 1'b1, 2'd3, 8'd100, 24'h646464, 24'h000000, 8'd127};
    vecs[8]  = '{1'b0, 1'b1, 2'd3, 8'd100, 24'hc8c8c8, 24'hffffff, 8'd127};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 8'd100, 24'h10c87f, 24'h00ff00, 8'd127};
    vecs[10] = '{1'b1, 1'b0, 2'd2, 8'd100, 24'h123456, 24'h123456, 8'd127};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 8'd0,   24'h000000, 24'h000000, 8'd0};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 8'd0,   24'h010101, 24'h010101, 8'd0};
    vecs[13] = '{1'b1, 1'b1, 2'd2, 8'd250, 24'h010203, 24'hffffff, 8'd255};

    do_reset();
    chk("rst_in_ready", 32'(in_ready), 1);

    // brightness ramp from 0 toward bpm 200, pass-through data
    v = '{1'b1, 1'b0, 2'd0, 8'd200, 24'h0a0b0c, 24'h0a0b0c, 8'd255};
`ifdef BRIGHT_RAMP_EN
    for (int k = 1; k <= 16; k++) begin
      v.exp_b = (k * 16 > 255) ? 8'd255 : 8'(k * 16);
      send(v, $sformatf("ramp%0d", k));
    end
`else
    send(v, "ramp1");
`endif

    do_reset();
    for (int i = 0; i < 14; i++) send(vecs[i], $sformatf("vec%0d", i));

    // drain before the burst
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);

    // backpressure burst: out_ready pattern 1,0,0,1 repeating
    sent = 0;
    got = 0;
    stalls = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data = bp_data(sent);
        in_sop = (sent == 0);
        filter_enable = 1'b1;
        filter_mode = 2'd2;
        bpm_estimate = 8'd100;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) chk("bp_hold", 32'(out_data), 32'(prev_data));
      if (out_valid && !out_ready) begin
        chk("bp_in_ready_low", 32'(in_ready), 0);
        stalls++;
      end
      acc = in_valid && in_ready;
      take = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (take) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_beat", 32'(out_data), 32'hffffffff);
        end else begin
          chk($sformatf("bp_data%0d", got), 32'(out_data), 32'(exp_q.pop_front()));
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(sat_add127(bp_data(sent)));
        sent++;
      end
    end
    chk("bp_got", 32'(got), 8);
    chk("bp_sent", 32'(sent), 8);
    chk("bp_queue_empty", 32'(exp_q.size()), 0);
    chk("bp_stalled", 32'(stalls > 0), 1);

    // reset while a beat is stalled in the output register
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sop = 1'b1;
    in_data = 24'habcdef;
    filter_enable = 1'b1;
    filter_mode = 2'd0;
    bpm_estimate = 8'd100;
    @(posedge clk);
    #1;
    chk("stall_valid", 32'(out_valid), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stall_in_ready", 32'(in_ready), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_bright", 32'(brightness), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_sop", 32'(out_sop), 0);
    @(negedge clk);
    reset = 1'b0;
    v = '{1'b0, 1'b1, 2'd3, 8'd100, 24'h646464, 24'h646464, 8'd0};
    send(v, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
